// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter between the
// instruction-fetch and data ports.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    SEL_I = 1'b0,
    SEL_D = 1'b1
  } sel_t;

  // Byte-lane enables: bit 0 drives the high (even) byte, bit 1 the low (odd) byte.
  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_EVEN = 2'b01;
  localparam logic [1:0] WE_ODD  = 2'b10;
  localparam logic [1:0] WE_WORD = 2'b11;

endpackage

// File: rtl/mem_arbiter16.sv
// Arbitrates one single-port 16-bit memory between instruction and data ports,
// sequencing fixed-latency reads and single-cycle writes with a one-cycle ack.
module mem_arbiter16
  import mem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES    = 2,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic [1:0]  d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ack,
  output logic [15:0] m_addr,
  output logic        m_oe,
  output logic [1:0]  m_we,
  output logic [15:0] m_dout,
  input  logic [15:0] m_din,
  output state_t      dbg_state
);

  localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int SCW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(WAIT_CYCLES - 1);
  localparam logic [SCW-1:0] STREAK_MAX = SCW'(MAX_DATA_BURST);

  state_t         state;
  sel_t           sel;
  logic [WCW-1:0] wait_cnt;
  logic [SCW-1:0] streak;

  logic force_i;
  logic grant_d;
  logic grant_i;

  // Data wins unless it has used up its burst allowance while fetch is waiting.
  always_comb begin
    force_i = (streak == STREAK_MAX) && i_req;
    grant_d = d_req && !force_i;
    grant_i = i_req && !grant_d;
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sel      <= SEL_I;
      wait_cnt <= '0;
      streak   <= '0;
      m_addr   <= '0;
      m_dout   <= '0;
      m_oe     <= 1'b0;
      m_we     <= WE_NONE;
      i_rdata  <= '0;
      d_rdata  <= '0;
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (grant_d) begin
            sel    <= SEL_D;
            m_addr <= d_addr;
            m_we   <= d_we;
            m_oe   <= (d_we == WE_NONE);
            m_dout <= (d_we == WE_NONE) ? 16'h0000 : d_wdata;
            if (streak != STREAK_MAX) streak <= streak + 1'b1;
            state  <= ACCESS;
          end else if (grant_i) begin
            sel    <= SEL_I;
            m_addr <= i_addr;
            m_we   <= WE_NONE;
            m_oe   <= 1'b1;
            m_dout <= 16'h0000;
            streak <= '0;
            state  <= ACCESS;
          end else if (!d_req) begin
            streak <= '0;
          end
        end

        ACCESS: begin
          // m_oe is only set for reads, so it doubles as the read/write flag.
          if (m_oe) begin
            if (wait_cnt == WAIT_LAST) begin
              m_oe <= 1'b0;
              if (sel == SEL_I) begin
                i_rdata <= m_din;
                i_ack   <= 1'b1;
              end else begin
                d_rdata <= m_din;
                d_ack   <= 1'b1;
              end
              state <= DONE;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end else begin
            m_we  <= WE_NONE;
            d_ack <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          m_oe  <= 1'b0;
          m_we  <= WE_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter16.sv
// Scoreboard bench for mem_arbiter16: drivers queue expected accesses and acks,
// a negedge monitor pops and compares whenever the DUT shows an access or ack.
module tb_mem_arbiter16;
  import mem_arb_pkg::*;

  localparam int WAIT_CYCLES    = 2;
  localparam int MAX_DATA_BURST = 4;
  localparam int ACK_TIMEOUT    = 100;

  typedef struct packed {
    logic        oe;
    logic [1:0]  we;
    logic [15:0] addr;
    logic [15:0] dout;
  } acc_t;

  typedef struct packed {
    logic [1:0]  we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } d_cmd_t;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic [1:0]  d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_ack;
  logic [15:0] m_addr;
  logic        m_oe;
  logic [1:0]  m_we;
  logic [15:0] m_dout;
  logic [15:0] m_din;
  state_t      dbg_state;

  acc_t        acc_q[$];
  logic        order_q[$];
  logic [15:0] i_exp_q[$];
  logic [15:0] d_exp_q[$];
  d_cmd_t      d_cmd_q[$];
  logic [15:0] mem[logic [14:0]];

  int checks = 0;
  int errors = 0;

  mem_arbiter16 #(
    .WAIT_CYCLES   (WAIT_CYCLES),
    .MAX_DATA_BURST(MAX_DATA_BURST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_ack    (i_ack),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .m_addr   (m_addr),
    .m_oe     (m_oe),
    .m_we     (m_we),
    .m_dout   (m_dout),
    .m_din    (m_din),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a[15:1])) return mem[a[15:1]];
    return 16'h0000;
  endfunction

  // Memory model: lane writes and read data, both settled mid-cycle.
  always @(negedge clk) begin
    logic [15:0] w;
    if (m_we != WE_NONE) begin
      w = mem_rd(m_addr);
      if (m_we[0]) w[15:8] = m_dout[15:8];
      if (m_we[1]) w[7:0]  = m_dout[7:0];
      mem[m_addr[15:1]] = w;
    end
    m_din = m_oe ? mem_rd(m_addr) : 16'h0000;
  end

  function automatic acc_t rd_acc(input logic [15:0] a);
    return '{oe: 1'b1, we: WE_NONE, addr: a, dout: 16'h0000};
  endfunction

  function automatic acc_t wr_acc(input logic [1:0] we, input logic [15:0] a, input logic [15:0] d);
    return '{oe: 1'b0, we: we, addr: a, dout: d};
  endfunction

  // ---------------- drivers ----------------
  task automatic wait_ack(input bit port_d, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < ACK_TIMEOUT; n++) begin
      @(negedge clk);
      if (port_d ? d_ack : i_ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_ack_timeout: got no ack expected ack within %0d cycles",
               port_d ? "d" : "i", ACK_TIMEOUT);
    end
  endtask

  task automatic i_read(input logic [15:0] a);
    bit ok;
    i_req  = 1'b1;
    i_addr = a;
    wait_ack(1'b0, ok);
    @(posedge clk);
    #1;
    i_req = 1'b0;
  endtask

  // Keeps d_req high across queued commands so the burst is back-to-back.
  task automatic d_run();
    d_cmd_t c;
    bit ok;
    if (d_cmd_q.size() == 0) return;
    c = d_cmd_q.pop_front();
    d_req = 1'b1; d_we = c.we; d_addr = c.addr; d_wdata = c.wdata;
    while (1) begin
      wait_ack(1'b1, ok);
      @(posedge clk);
      #1;
      if (!ok || d_cmd_q.size() == 0) begin
        d_req = 1'b0;
        d_we  = WE_NONE;
        break;
      end
      c = d_cmd_q.pop_front();
      d_we = c.we; d_addr = c.addr; d_wdata = c.wdata;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int   oe_run = 0;
  int   we_run = 0;
  logic prev_active = 1'b0;

  always @(negedge clk) begin
    logic active;
    acc_t a;
    logic port;
    if (!rst) begin
      oe_run      = 0;
      we_run      = 0;
      prev_active = 1'b0;
    end else begin
      active = m_oe || (m_we != WE_NONE);
      if (active) chk("oe_we_exclusive", 16'(m_oe && (m_we != WE_NONE)), 16'h0);
      if (active && !prev_active) begin
        if (acc_q.size() == 0) begin
          chk("unexpected_access", m_addr, 16'hxxxx);
        end else begin
          a = acc_q.pop_front();
          chk("acc_oe",   16'(m_oe), 16'(a.oe));
          chk("acc_we",   16'(m_we), 16'(a.we));
          chk("acc_addr", m_addr,    a.addr);
          chk("acc_dout", m_dout,    a.dout);
        end
      end
      if (m_oe) oe_run++;
      else if (oe_run > 0) begin
        chk("oe_cycles", 16'(oe_run), 16'(WAIT_CYCLES));
        oe_run = 0;
      end
      if (m_we != WE_NONE) we_run++;
      else if (we_run > 0) begin
        chk("we_cycles", 16'(we_run), 16'd1);
        we_run = 0;
      end
      if (i_ack || d_ack) begin
        chk("ack_exclusive", 16'(i_ack && d_ack), 16'h0);
        chk("ack_after_access", 16'(prev_active), 16'h1);
        if (order_q.size() == 0) begin
          chk("unexpected_ack", {14'h0, d_ack, i_ack}, 16'h0);
        end else begin
          port = order_q.pop_front();
          chk("ack_port_is_d", 16'(d_ack), 16'(port));
        end
        if (d_ack) begin
          if (d_exp_q.size() == 0) chk("unexpected_d_ack", d_rdata, 16'hxxxx);
          else chk("d_rdata", d_rdata, d_exp_q.pop_front());
        end
        if (i_ack) begin
          if (i_exp_q.size() == 0) chk("unexpected_i_ack", i_rdata, 16'hxxxx);
          else chk("i_rdata", i_rdata, i_exp_q.pop_front());
        end
      end
      prev_active = active;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = WE_NONE; d_addr = '0; d_wdata = '0;
    m_din = '0;

    mem[15'(16'h0010 >> 1)] = 16'h1234;
    mem[15'(16'h0012 >> 1)] = 16'h5678;
    mem[15'(16'h0014 >> 1)] = 16'h9ABC;
    mem[15'(16'h0016 >> 1)] = 16'hDEF0;
    mem[15'(16'h0020 >> 1)] = 16'h2222;
    mem[15'(16'h0200 >> 1)] = 16'hA5A5;
    for (int k = 0; k < 8; k++) mem[15'((16'h0300 + 16'(2 * k)) >> 1)] = 16'h3000 + 16'(k);

    // Reset values.
    @(negedge clk);
    chk("rst_state",   16'(dbg_state), 16'(IDLE));
    chk("rst_m_addr",  m_addr,  16'h0);
    chk("rst_m_dout",  m_dout,  16'h0);
    chk("rst_m_oe",    16'(m_oe), 16'h0);
    chk("rst_m_we",    16'(m_we), 16'h0);
    chk("rst_i_rdata", i_rdata, 16'h0);
    chk("rst_d_rdata", d_rdata, 16'h0);
    chk("rst_i_ack",   16'(i_ack), 16'h0);
    chk("rst_d_ack",   16'(d_ack), 16'h0);
    @(negedge clk);
    rst = 1'b1;

    // 1: single instruction read.
    acc_q.push_back(rd_acc(16'h0010));
    order_q.push_back(1'b0);
    i_exp_q.push_back(16'h1234);
    @(posedge clk); #1;
    i_read(16'h0010);

    // 2: simultaneous requests, data first.
    acc_q.push_back(rd_acc(16'h0200));
    acc_q.push_back(rd_acc(16'h0012));
    order_q.push_back(1'b1);
    order_q.push_back(1'b0);
    d_exp_q.push_back(16'hA5A5);
    i_exp_q.push_back(16'h5678);
    d_cmd_q.push_back('{we: WE_NONE, addr: 16'h0200, wdata: 16'h0});
    @(posedge clk); #1;
    fork
      d_run();
      i_read(16'h0012);
    join

    // 3: continuous data burst starves fetch for exactly MAX_DATA_BURST grants.
    for (int k = 0; k < 8; k++) begin
      d_cmd_q.push_back('{we: WE_NONE, addr: 16'h0300 + 16'(2 * k), wdata: 16'h0});
      d_exp_q.push_back(16'h3000 + 16'(k));
    end
    for (int k = 0; k < 4; k++) begin
      acc_q.push_back(rd_acc(16'h0300 + 16'(2 * k)));
      order_q.push_back(1'b1);
    end
    acc_q.push_back(rd_acc(16'h0014));
    order_q.push_back(1'b0);
    for (int k = 4; k < 8; k++) begin
      acc_q.push_back(rd_acc(16'h0300 + 16'(2 * k)));
      order_q.push_back(1'b1);
    end
    acc_q.push_back(rd_acc(16'h0016));
    order_q.push_back(1'b0);
    i_exp_q.push_back(16'h9ABC);
    i_exp_q.push_back(16'hDEF0);
    @(posedge clk); #1;
    fork
      d_run();
      begin
        i_read(16'h0014);
        i_read(16'h0016);
      end
    join

    // 4: word write leaves d_rdata at the last read value.
    acc_q.push_back(wr_acc(WE_WORD, 16'h0100, 16'hBEEF));
    order_q.push_back(1'b1);
    d_exp_q.push_back(16'h3007);
    d_cmd_q.push_back('{we: WE_WORD, addr: 16'h0100, wdata: 16'hBEEF});
    @(posedge clk); #1;
    d_run();

    // 5: byte-lane writes, then read back the merged word and the word write.
    acc_q.push_back(wr_acc(WE_EVEN, 16'h0102, 16'h7700));
    acc_q.push_back(wr_acc(WE_ODD,  16'h0103, 16'h0055));
    acc_q.push_back(rd_acc(16'h0102));
    acc_q.push_back(rd_acc(16'h0100));
    for (int k = 0; k < 4; k++) order_q.push_back(1'b1);
    d_exp_q.push_back(16'h3007);
    d_exp_q.push_back(16'h3007);
    d_exp_q.push_back(16'h7755);
    d_exp_q.push_back(16'hBEEF);
    d_cmd_q.push_back('{we: WE_EVEN, addr: 16'h0102, wdata: 16'h7700});
    d_cmd_q.push_back('{we: WE_ODD,  addr: 16'h0103, wdata: 16'h0055});
    d_cmd_q.push_back('{we: WE_NONE, addr: 16'h0102, wdata: 16'h0});
    d_cmd_q.push_back('{we: WE_NONE, addr: 16'h0100, wdata: 16'h0});
    @(posedge clk); #1;
    d_run();

    // 6: reset during the first m_oe cycle aborts the read without an ack.
    acc_q.push_back(rd_acc(16'h0020));
    @(posedge clk); #1;
    i_req  = 1'b1;
    i_addr = 16'h0020;
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < ACK_TIMEOUT; n++) begin
        @(negedge clk);
        if (m_oe) begin
          seen = 1'b1;
          break;
        end
      end
      chk("abort_oe_seen", 16'(seen), 16'h1);
    end
    #1 rst = 1'b0;
    #1;
    chk("abort_m_oe",    16'(m_oe), 16'h0);
    chk("abort_m_we",    16'(m_we), 16'h0);
    chk("abort_i_ack",   16'(i_ack), 16'h0);
    chk("abort_state",   16'(dbg_state), 16'(IDLE));
    chk("abort_i_rdata", i_rdata, 16'h0);
    repeat (2) @(negedge clk);
    acc_q.push_back(rd_acc(16'h0020));
    order_q.push_back(1'b0);
    i_exp_q.push_back(16'h2222);
    rst = 1'b1;
    begin
      bit ok;
      wait_ack(1'b0, ok);
    end
    @(posedge clk); #1;
    i_req = 1'b0;

    repeat (4) @(negedge clk);
    chk("end_state",      16'(dbg_state), 16'(IDLE));
    chk("acc_q_left",     16'(acc_q.size()),   16'h0);
    chk("order_q_left",   16'(order_q.size()), 16'h0);
    chk("i_exp_q_left",   16'(i_exp_q.size()), 16'h0);
    chk("d_exp_q_left",   16'(d_exp_q.size()), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
